// File: rtl/pgm_gen_sched.sv
// pgm_gen_sched: replays a packet stored in PGM RAM at addresses 0..last_addr.
// The packet is sent a programmed number of times, or without limit until a
// stop is requested, with a programmable idle gap between packets.
// Optional feature: define PGM_SEQ_STAMP_EN to overwrite bits [31:0] of the
// word read from address 1 with the 0-based packet index within the run.
module pgm_gen_sched #(
    parameter string       PLATFORM = "Xilinx",   // vendor tag only, no functional effect
    parameter int unsigned GAP_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [6:0]       cfg_last_addr,
    input  logic [31:0]      cfg_repeat,
    input  logic [GAP_W-1:0] cfg_gap,
    output logic             ram_rd_en,
    output logic [6:0]       ram_addr,
    input  logic [143:0]     ram_rdata,
    output logic [133:0]     out_data,
    output logic             out_data_wr,
    output logic             out_valid,
    output logic             out_valid_wr,
    input  logic             in_alf,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sent_cnt
);

    typedef enum logic [1:0] {IDLE, READ, GAP, FIN} state_e;

    state_e           state_q, state_d;
    logic [6:0]       last_q;                 // run configuration, captured at start
    logic [31:0]      repeat_q;
    logic [GAP_W-1:0] gap_q;
    logic             cfg_load;
    logic [6:0]       addr_q, addr_d;         // next address once the head is out
    logic [6:0]       rd_addr;
    logic             reading_q, reading_d;   // head issued, rest of packet streams
    logic             stop_q, stop_d;         // stop requested, honoured after the tail
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             wr_q, wr_d;             // a word read last cycle is on the bus now
    logic             tail_q, tail_d;

    // Only the low 134 data bits are forwarded.
    logic unused_ok;
    assign unused_ok = &{1'b0, ram_rdata[143:134], (PLATFORM == "")};

    // Next-state, read strobe and register updates of the scheduler FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        reading_d = reading_q;
        stop_d    = stop_q;
        gap_cnt_d = gap_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        wr_d      = 1'b0;
        tail_d    = 1'b0;
        cfg_load  = 1'b0;
        ram_rd_en = 1'b0;
        ram_addr  = '0;
        rd_addr   = reading_q ? addr_q : 7'd0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    cfg_load  = 1'b1;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    stop_d    = cfg_stop;   // start+stop together: one packet
                    reading_d = 1'b0;
                    addr_d    = '0;
                    state_d   = READ;
                end
            end
            READ: begin
                stop_d = stop_q | cfg_stop;
                // Almost-full only gates the head; once started, a packet never stalls.
                if (reading_q || !in_alf) begin
                    ram_rd_en = 1'b1;
                    ram_addr  = rd_addr;
                    wr_d      = 1'b1;
                    if (rd_addr == last_q) begin
                        tail_d    = 1'b1;
                        cnt_d     = cnt_q + 32'd1;
                        reading_d = 1'b0;
                        addr_d    = '0;
                        if (stop_q || cfg_stop || (repeat_q != '0 && cnt_d == repeat_q)) begin
                            state_d = FIN;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q - GAP_W'(1);
                        end
                    end else begin
                        reading_d = 1'b1;
                        addr_d    = rd_addr + 7'd1;
                    end
                end
            end
            GAP: begin
                if (cfg_stop) begin
                    state_d = FIN;
                end else if (gap_cnt_q == '0) begin
                    state_d = READ;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            FIN: begin
                // FIN is always entered while the final word is on the bus, so
                // it is complete by the time done is raised.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            reading_q <= 1'b0;
            stop_q    <= 1'b0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            tail_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q   <= state_d;
            addr_q    <= addr_d;
            reading_q <= reading_d;
            stop_q    <= stop_d;
            gap_cnt_q <= gap_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            tail_q    <= tail_d;
        end
    end

    // Run configuration shadow, loaded only when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= '0;
            repeat_q <= '0;
            gap_q    <= '0;
        end else if (cfg_load) begin
            last_q   <= cfg_last_addr;
            repeat_q <= cfg_repeat;
            gap_q    <= cfg_gap;
        end
    end

`ifdef PGM_SEQ_STAMP_EN
    logic        stamp_q;
    logic [31:0] stamp_val_q;

    // Mark the word read from address 1 and capture this packet's index for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_q     <= 1'b0;
            stamp_val_q <= '0;
        end else begin
            stamp_q     <= ram_rd_en && (ram_addr == 7'd1);
            stamp_val_q <= cnt_q;
        end
    end
`endif

    // Output word: RAM data (framing bits untouched) while a word is being written.
    always_comb begin
        out_data = wr_q ? ram_rdata[133:0] : '0;
`ifdef PGM_SEQ_STAMP_EN
        if (stamp_q) begin
            out_data[31:0] = stamp_val_q;
        end
`endif
    end

    assign out_data_wr  = wr_q;
    assign out_valid    = tail_q;
    assign out_valid_wr = tail_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sent_cnt     = cnt_q;

endmodule

// File: tb/tb_pgm_gen_sched.sv
// Scoreboard bench for pgm_gen_sched. Each run pushes the packet words and the
// final done it should produce; a monitor pops and compares as the DUT emits.
// Packet timing is checked from closed-form cycle arithmetic.
module tb_pgm_gen_sched;

    localparam int GAP_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic             cfg_stop = 1'b0;
    logic [6:0]       cfg_last_addr = '0;
    logic [31:0]      cfg_repeat = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic             ram_rd_en;
    logic [6:0]       ram_addr;
    logic [143:0]     ram_rdata = '0;
    logic [133:0]     out_data;
    logic             out_data_wr, out_valid, out_valid_wr;
    logic             in_alf = 1'b0;
    logic             busy, done;
    logic [31:0]      sent_cnt;

    always #5 clk = ~clk;

    pgm_gen_sched #(.PLATFORM("Xilinx"), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_last_addr(cfg_last_addr), .cfg_repeat(cfg_repeat), .cfg_gap(cfg_gap),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .out_data(out_data), .out_data_wr(out_data_wr), .out_valid(out_valid),
        .out_valid_wr(out_valid_wr), .in_alf(in_alf), .busy(busy), .done(done),
        .sent_cnt(sent_cnt)
    );

    typedef struct {
        logic [133:0] data;
        bit           head;
        bit           tail;
        bit           first;   // first packet of the run: no gap before it
        logic [31:0]  cnt;     // sent_cnt visible with this word
    } word_t;

    word_t        exp_q[$];
    logic [31:0]  done_exp_q[$];
    logic [143:0] mem [128];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit sb_en    = 1'b0;
    int exp_gap  = 0;
    bit gap_exact = 1'b0;
    int prev_cyc = 0;
    int last_tail_cyc = 0;
    int first_rd = -1;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [143:0] rand144();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[143:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: one-cycle read latency, noise on the bus when not reading.
    always @(posedge clk) ram_rdata <= ram_rd_en ? mem[ram_addr] : rand144();

    // Cycle of the first read strobe of the current run.
    always @(negedge clk) if (ram_rd_en && first_rd < 0) first_rd = cyc;

    // Monitor: compare every emitted word and every done against the scoreboard.
    always @(negedge clk) begin
        word_t w;
        logic [31:0] n;
        if (rst_n && sb_en) begin
            if (out_valid || out_valid_wr) check("tail_has_word", out_data_wr, 1);
            if (out_data_wr) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("data", out_data, w.data);
                    check("tail_flags", {out_valid, out_valid_wr}, {w.tail, w.tail});
                    check("sent_cnt", sent_cnt, w.cnt);
                    if (!w.head) check("contiguous", cyc - prev_cyc, 1);
                    else if (!w.first && gap_exact) check("gap_idle", cyc - last_tail_cyc - 1, exp_gap);
                    prev_cyc = cyc;
                    if (w.tail) last_tail_cyc = cyc;
                end
            end
            if (done) begin
                check("done_expected", done_exp_q.size() != 0, 1);
                if (done_exp_q.size() != 0) begin
                    n = done_exp_q.pop_front();
                    check("done_sent_cnt", sent_cnt, n);
                    check("busy_at_done", busy, 0);
                end
            end
        end
    end

    task automatic check_idle(input string tag, input bit with_cnt);
        check({tag, "_ctl"}, {ram_rd_en, out_data_wr, out_valid, out_valid_wr, busy, done}, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_data"}, out_data, 0);
        if (with_cnt) check({tag, "_cnt"}, sent_cnt, 0);
    endtask

    // One generation run. stop_at: 0 none, -1 with start, K>0 during packet K
    // (or in the gap after packet K when stop_in_gap).
    task automatic run(input logic [6:0] last, input logic [31:0] rep, input logic [GAP_W-1:0] gap,
                       input int stop_at, input bit stop_in_gap, input int alf_hold, input bit alf_rand);
        int npk, t0, done_at, stop_cyc, gap_wait, exp_first;
        bit seen_done;
        word_t w;
        for (int a = 0; a < 128; a++) mem[a] = rand144();
        npk = (stop_at < 0) ? 1 : (stop_at > 0) ? stop_at : int'(rep);
        for (int p = 0; p < npk; p++) begin
            for (int a = 0; a <= int'(last); a++) begin
                w.data = mem[a][133:0];
`ifdef PGM_SEQ_STAMP_EN
                if (a == 1) w.data[31:0] = p;
`endif
                w.head  = (a == 0);
                w.tail  = (a == int'(last));
                w.first = (p == 0);
                w.cnt   = (a == int'(last)) ? p + 1 : p;
                exp_q.push_back(w);
            end
        end
        done_exp_q.push_back(npk);
        exp_gap   = int'(gap);
        gap_exact = !alf_rand;

        @(posedge clk); #1;
        t0 = cyc;
        first_rd = -1;
        cfg_last_addr = last; cfg_repeat = rep; cfg_gap = gap;
        cfg_start = 1'b1; cfg_stop = (stop_at < 0); in_alf = (alf_hold > 0);
        seen_done = 1'b0; done_at = 0; stop_cyc = -1; gap_wait = -1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen_done = 1'b1;
                done_at = cyc;
                break;
            end
            // Noise that a busy block must ignore.
            cfg_start     = busy && ($urandom_range(7) == 0);
            cfg_stop      = 1'b0;
            cfg_last_addr = 7'($urandom);
            cfg_repeat    = $urandom_range(3);
            cfg_gap       = GAP_W'($urandom_range(3));
            in_alf        = alf_rand ? ($urandom_range(2) == 0) : (cyc - t0 < alf_hold);
            if (stop_at > 0 && stop_cyc < 0) begin
                if (!stop_in_gap) begin
                    if (out_data_wr && !out_valid && sent_cnt == stop_at - 1) begin
                        cfg_stop = 1'b1; stop_cyc = cyc;
                    end
                end else if (gap_wait < 0) begin
                    if (out_valid && sent_cnt == stop_at) gap_wait = 2;
                end else begin
                    gap_wait--;
                    if (gap_wait == 0) begin
                        cfg_stop = 1'b1; stop_cyc = cyc;
                    end
                end
            end
        end
        cfg_start = 1'b0; cfg_stop = 1'b0; in_alf = 1'b0;
        check("done_seen", seen_done, 1);
        if (!seen_done) begin
            rst_n = 1'b0;
            #1;
            exp_q.delete();
            done_exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            if (!alf_rand) begin
                exp_first = t0 + ((alf_hold > 1) ? alf_hold : 1);
                check("first_rd_cycle", first_rd, exp_first);
                if (stop_in_gap) check("done_cycle", done_at, stop_cyc + 2);
                else check("done_cycle", done_at,
                           exp_first + npk * (int'(last) + 1) + (npk - 1) * int'(gap) + 1);
            end
            @(negedge clk); #1;
            check("words_left", exp_q.size(), 0);
            check("dones_left", done_exp_q.size(), 0);
        end
    endtask

    initial begin
        int nw;
        #12;
        check_idle("reset", 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_en = 1'b1;

        run(7'd3, 32'd1, 16'd0, 0, 1'b0, 0, 1'b0);     // single packet
        run(7'd1, 32'd3, 16'd5, 0, 1'b0, 0, 1'b0);     // gap timing
        run(7'd5, 32'd1, 16'd0, 0, 1'b0, 10, 1'b0);    // backpressure over start
        run(7'd3, 32'd0, 16'd0, 4, 1'b0, 0, 1'b0);     // stop during packet 4
        run(7'd0, 32'd4, 16'd2, 0, 1'b0, 0, 1'b0);     // one-word packets
        run(7'd2, 32'd0, 16'd0, -1, 1'b0, 0, 1'b0);    // start and stop together
        run(7'd2, 32'd0, 16'd8, 2, 1'b1, 0, 1'b0);     // stop inside a gap

        // A stop while idle does nothing.
        @(posedge clk); #1; cfg_stop = 1'b1;
        @(posedge clk); #1; cfg_stop = 1'b0;
        repeat (4) @(posedge clk);
        #1; check_idle("stop_idle", 1'b0);

        // Reset during word 2 of a 4-word packet.
        sb_en = 1'b0;
        @(posedge clk); #1;
        cfg_last_addr = 7'd3; cfg_repeat = 32'd0; cfg_gap = '0; cfg_start = 1'b1;
        nw = 0;
        for (int i = 0; i < 50 && nw < 2; i++) begin
            @(posedge clk); #1;
            cfg_start = 1'b0;
            if (out_data_wr) nw++;
        end
        check("reset_word_reached", nw, 2);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset", 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("held_reset", 1'b1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_en = 1'b1;
        run(7'd3, 32'd3, 16'd1, 0, 1'b0, 0, 1'b0);     // rerun after reset

        for (int k = 0; k < 6; k++) begin
            run(7'($urandom_range(15)), $urandom_range(5, 1), GAP_W'($urandom_range(6)),
                0, 1'b0, 0, k[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pgm_gen_sched.md
PGM_GEN_SCHED -- requirements
Module: pgm_gen_sched

Interface
REQ-001 SHALL have parameter PLATFORM, default "Xilinx", target vendor tag with no functional effect.
REQ-002 SHALL have parameter GAP_W, default 16, width of the inter-packet gap counter.
REQ-003 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_start  in  1  one-cycle pulse that starts a generation run.
REQ-006 SHALL have port cfg_stop  in  1  one-cycle pulse that requests a graceful abort.
REQ-007 SHALL have port cfg_last_addr  in  7  RAM address of the stored packet's tail word.
REQ-008 SHALL have port cfg_repeat  in  32  packets to send; 0 means continuous until stopped.
REQ-009 SHALL have port cfg_gap  in  GAP_W  idle cycles between packets.
REQ-010 SHALL have port ram_rd_en  out  1  PGM RAM read strobe.
REQ-011 SHALL have port ram_addr  out  7  PGM RAM read address.
REQ-012 SHALL have port ram_rdata  in  144  RAM data, valid exactly 1 cycle after ram_rd_en.
REQ-013 SHALL have ports out_data  out  134,  out_data_wr  out  1,  out_valid  out  1,  out_valid_wr  out  1: the generated packet stream.
REQ-014 SHALL have port in_alf  in  1  downstream almost-full.
REQ-015 SHALL have ports busy  out  1,  done  out  1 (one-cycle pulse),  sent_cnt  out  32 (packets sent in the current run).

Function
REQ-016 SHALL implement states IDLE, READ, GAP and FIN.
REQ-017 IDLE: on cfg_start, SHALL latch cfg_last_addr, cfg_repeat and cfg_gap, clear sent_cnt, assert busy, and go to READ.
REQ-018 While busy, cfg_start SHALL be ignored; changes to the cfg_* inputs SHALL have no effect until the next start.
REQ-019 READ SHALL sample in_alf only before the head read; while in_alf=1, no read is issued. Once the head read is issued, addresses 0..last_addr SHALL be read on consecutive cycles with no stalls.
REQ-020 Each read SHALL produce, exactly 1 cycle later, out_data=ram_rdata[133:0] with out_data_wr=1.
REQ-021 The tail word SHALL carry out_valid_wr=1 and out_valid=1, and sent_cnt SHALL increment in the same cycle.
REQ-022 The cycle after the tail read, the block SHALL go to GAP when cfg_gap>0, otherwise directly to READ or FIN; GAP SHALL last exactly cfg_gap cycles.
REQ-023 After the packet whose tail makes sent_cnt equal cfg_repeat (cfg_repeat≠0), the block SHALL go to FIN and skip GAP.
REQ-024 FIN SHALL wait for the last output word to be emitted, then pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-025 On cfg_stop during READ, the current packet SHALL complete, then the block SHALL go to FIN. On cfg_stop during GAP, it SHALL go to FIN immediately. On cfg_stop in IDLE, nothing SHALL happen.
REQ-026 If cfg_start and cfg_stop arrive in the same cycle in IDLE, the run SHALL start and finish after 1 packet.
REQ-027 If last_addr=0, the packet SHALL be one word, and the head is also the tail.
REQ-028 sent_cnt SHALL wrap from 2^32-1 to 0 in continuous mode.
REQ-029 The block SHALL never modify ram_rdata[133:132]; framing bits SHALL pass through as stored.

Reset
REQ-030 On rst_n=0, all outputs and sent_cnt SHALL go to 0, the state SHALL go to IDLE, and any in-flight packet SHALL be dropped with no tail emitted.
REQ-031 Release of rst_n SHALL take effect synchronously to clk; the first cfg_start SHALL be accepted on the cycle after release.

Configuration
REQ-032 With PGM_SEQ_STAMP_EN defined, the word read from address 1 SHALL have out_data[31:0] replaced by the 0-based packet index of the run; when last_addr=0, no stamping occurs.
REQ-033 Without PGM_SEQ_STAMP_EN, data SHALL pass through unchanged and no stamp logic SHALL exist.

Verification
REQ-034 Single packet: last_addr=3, repeat=1, gap=0, start at T -> rd_en at T+1..T+4, out_data_wr at T+2..T+5, tail valid at T+5, done at T+6, sent_cnt=1.
REQ-035 Gap timing: last_addr=1, repeat=3, gap=5 -> three 2-word packets with exactly 5 idle cycles between tail output and the next head output, then done.
REQ-036 Backpressure: hold in_alf=1 over the start for 10 cycles -> no rd_en until in_alf falls; then the packet is emitted contiguously.
REQ-037 Stop: repeat=0, gap=0, pulse cfg_stop mid-packet 4 -> packet 4 completes, done pulses, sent_cnt=4.
REQ-038 Reset mid-packet (rst_n low at word 2 of 4) -> outputs 0 the same cycle, no tail, state IDLE; with PGM_SEQ_STAMP_EN, a rerun stamps 0,1,2 into word 1 [31:0].
